// File: rtl/tpu_timer_mc_pkg.sv
// tpu_timer_pkg: shared types and default sizing for the multi-channel TPU timer.
// Contents:
//   TPU_CNT_W / TPU_CYC_W / TPU_NUM_CH : default counter width, cycle-in-window width and
//                                        channel count
//   TPU_PRESCALE_W                     : width of the optional prescaler (TPU_PRESCALER_EN)
//   ch_cfg_t                           : per-channel configuration {cmp, en, oneshot, mask}
//   idx_width()                        : channel index width, never below 1 bit
package tpu_timer_pkg;

    localparam int unsigned TPU_CNT_W      = 16;
    localparam int unsigned TPU_CYC_W      = 9;
    localparam int unsigned TPU_NUM_CH     = 4;
    localparam int unsigned TPU_PRESCALE_W = 8;

    // cmp is sized by TPU_CNT_W; a top-level CNT_W override must change this constant too.
    typedef struct packed {
        logic [TPU_CNT_W-1:0] cmp;
        logic                 en;
        logic                 oneshot;
        logic                 mask;
    } ch_cfg_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tpu_timer_mc_if.sv
// tpu_timer_mc_if: channel configuration / flag-clear bus of the multi-channel TPU timer.
// Signals:
//   cfg_wr      : config write strobe
//   cfg_idx     : target channel of cfg_wr
//   cfg_cmp     : compare value
//   cfg_en      : channel armed
//   cfg_oneshot : 1 = disarm after first match, 0 = periodic
//   cfg_mask    : 1 = flag contributes to tpu_int
//   flag_clr    : write-1-to-clear per-channel flags
// Modports: master (register block side, drives), slave (timer side, receives).
interface tpu_timer_mc_if
    import tpu_timer_pkg::*;
#(
    parameter int unsigned CNT_W  = TPU_CNT_W,
    parameter int unsigned NUM_CH = TPU_NUM_CH,
    parameter int unsigned IDX_W  = idx_width(NUM_CH)
);

    logic              cfg_wr;
    logic [IDX_W-1:0]  cfg_idx;
    logic [CNT_W-1:0]  cfg_cmp;
    logic              cfg_en;
    logic              cfg_oneshot;
    logic              cfg_mask;
    logic [NUM_CH-1:0] flag_clr;

    modport master (
        output cfg_wr, cfg_idx, cfg_cmp, cfg_en, cfg_oneshot, cfg_mask, flag_clr
    );

    modport slave (
        input cfg_wr, cfg_idx, cfg_cmp, cfg_en, cfg_oneshot, cfg_mask, flag_clr
    );

endinterface

// File: rtl/tpu_timer_mc_cmp_channel.sv
// tpu_cmp_channel: one compare channel of the multi-channel TPU timer.
// Holds its configuration, armed state and sticky match flag.
// Ports:
//   sys_clock, reset : clock, synchronous active-high reset
//   counter          : registered timer count
//   wr, wr_cfg       : load new configuration (also clears the flag)
//   clr              : write-1-to-clear flag; loses against a simultaneous match
//   flag             : sticky match flag
//   armed            : channel currently armed
//   masked_flag      : flag & mask, feeds the interrupt OR
module tpu_cmp_channel
    import tpu_timer_pkg::*;
(
    input  logic                 sys_clock,
    input  logic                 reset,
    input  logic [TPU_CNT_W-1:0] counter,
    input  logic                 wr,
    input  ch_cfg_t              wr_cfg,
    input  logic                 clr,
    output logic                 flag,
    output logic                 armed,
    output logic                 masked_flag
);

    // cfg_q.en doubles as the armed state; a one-shot match clears it.
    ch_cfg_t cfg_q, cfg_d;
    logic    flag_q, flag_d;
    logic    match;

    assign match = cfg_q.en && (counter == cfg_q.cmp);

    always_comb begin
        cfg_d  = cfg_q;
        flag_d = flag_q;
        if (wr) begin
            // A match on the old configuration in the write cycle is dropped.
            cfg_d  = wr_cfg;
            flag_d = 1'b0;
        end else if (match) begin
            flag_d = 1'b1;
            if (cfg_q.oneshot) begin
                cfg_d.en = 1'b0;
            end
        end else if (clr) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            cfg_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            cfg_q  <= cfg_d;
            flag_q <= flag_d;
        end
    end

    assign flag        = flag_q;
    assign armed       = cfg_q.en;
    assign masked_flag = flag_q & cfg_q.mask;

endmodule

// File: rtl/tpu_timer_mc.sv
// tpu_timer_mc: multi-channel TPU timer.
// Free-running counter split into window index (upper bits) and cycle-in-window (lower
// bits), NUM_CH compare channels with sticky flags, and a registered masked interrupt.
// Optional feature: define TPU_PRESCALER_EN to add prescale_div and an 8-bit prescaler.
// Ports:
//   sys_clock, reset : clock, synchronous active-high reset (overrides everything)
//   rsttpu           : synchronous counter clear, channel state untouched
//   cnt_en           : counter advance enable
//   cfg              : channel config / flag-clear bus (tpu_timer_mc_if.slave)
//   prescale_div     : advance once every prescale_div+1 enabled cycles (TPU_PRESCALER_EN)
//   counter          : current count; window_idx / cycle_idx are its upper / lower fields
//   window_start     : one-cycle pulse while a freshly loaded count has cycle_idx == 0
//   intflag, ch_armed: per-channel sticky flags and armed state
//   tpu_int          : registered OR of masked flags
module tpu_timer_mc
    import tpu_timer_pkg::*;
#(
    parameter int unsigned CNT_W  = TPU_CNT_W,
    parameter int unsigned CYC_W  = TPU_CYC_W,
    parameter int unsigned NUM_CH = TPU_NUM_CH
) (
    input  logic                    sys_clock,
    input  logic                    reset,
    input  logic                    rsttpu,
    input  logic                    cnt_en,
    tpu_timer_mc_if.slave           cfg,
`ifdef TPU_PRESCALER_EN
    input  logic [TPU_PRESCALE_W-1:0] prescale_div,
`endif
    output logic [CNT_W-1:0]        counter,
    output logic [CNT_W-CYC_W-1:0]  window_idx,
    output logic [CYC_W-1:0]        cycle_idx,
    output logic                    window_start,
    output logic [NUM_CH-1:0]       intflag,
    output logic [NUM_CH-1:0]       ch_armed,
    output logic                    tpu_int
);

    localparam int unsigned IDX_W = idx_width(NUM_CH);

    logic [CNT_W-1:0]  counter_q, counter_d;
    logic              window_start_q, window_start_d;
    logic              tpu_int_q;
    logic              advance;
    logic [NUM_CH-1:0] masked;
    ch_cfg_t           wr_cfg;

`ifdef TPU_PRESCALER_EN
    logic [TPU_PRESCALE_W-1:0] presc_q, presc_d;
    logic                      presc_hit;

    // >= rather than == so a divider lowered below the running count fires at once.
    assign presc_hit = (presc_q >= prescale_div);
    assign advance   = cnt_en && presc_hit;

    always_comb begin
        presc_d = presc_q;
        if (rsttpu) begin
            presc_d = '0;
        end else if (cnt_en) begin
            presc_d = presc_hit ? '0 : presc_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    assign advance = cnt_en;
`endif

    always_comb begin
        counter_d = counter_q;
        if (rsttpu) begin
            counter_d = '0;
        end else if (advance) begin
            counter_d = counter_q + 1'b1;
        end
        // Only a real load counts; sitting at 0 out of reset does not pulse.
        window_start_d = (rsttpu || advance) && (counter_d[CYC_W-1:0] == '0);
    end

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            counter_q      <= '0;
            window_start_q <= 1'b0;
            tpu_int_q      <= 1'b0;
        end else begin
            counter_q      <= counter_d;
            window_start_q <= window_start_d;
            tpu_int_q      <= |masked;
        end
    end

    assign wr_cfg.cmp     = cfg.cfg_cmp;
    assign wr_cfg.en      = cfg.cfg_en;
    assign wr_cfg.oneshot = cfg.cfg_oneshot;
    assign wr_cfg.mask    = cfg.cfg_mask;

    // Out-of-range cfg_idx matches no channel and is therefore ignored.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tpu_cmp_channel u_ch (
            .sys_clock   (sys_clock),
            .reset       (reset),
            .counter     (counter_q),
            .wr          (cfg.cfg_wr && (cfg.cfg_idx == IDX_W'(i))),
            .wr_cfg      (wr_cfg),
            .clr         (cfg.flag_clr[i]),
            .flag        (intflag[i]),
            .armed       (ch_armed[i]),
            .masked_flag (masked[i])
        );
    end

    assign counter      = counter_q;
    assign window_idx   = counter_q[CNT_W-1:CYC_W];
    assign cycle_idx    = counter_q[CYC_W-1:0];
    assign window_start = window_start_q;
    assign tpu_int      = tpu_int_q;

endmodule

// File: tb/tb_tpu_timer_mc.sv
// tb_tpu_timer_mc: bench for tpu_timer_mc. A behavioural model tracks the timer from the
// rules (count arithmetic, per-channel records) and is compared every cycle; directed
// steps pin the model with literal expectations, then randomized traffic follows.
module tb_tpu_timer_mc;
    import tpu_timer_pkg::*;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned CYC_W  = 9;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned MOD    = 1 << CNT_W;
    localparam int unsigned CYCMOD = 1 << CYC_W;

    logic                    sys_clock = 1'b0;
    logic                    reset;
    logic                    rsttpu;
    logic                    cnt_en;
`ifdef TPU_PRESCALER_EN
    logic [7:0]              prescale_div;
`endif
    logic [CNT_W-1:0]        counter;
    logic [CNT_W-CYC_W-1:0]  window_idx;
    logic [CYC_W-1:0]        cycle_idx;
    logic                    window_start;
    logic [NUM_CH-1:0]       intflag;
    logic [NUM_CH-1:0]       ch_armed;
    logic                    tpu_int;

    tpu_timer_mc_if #(.CNT_W(CNT_W), .NUM_CH(NUM_CH)) bus ();

    tpu_timer_mc #(.CNT_W(CNT_W), .CYC_W(CYC_W), .NUM_CH(NUM_CH)) dut (
        .sys_clock    (sys_clock),
        .reset        (reset),
        .rsttpu       (rsttpu),
        .cnt_en       (cnt_en),
        .cfg          (bus),
`ifdef TPU_PRESCALER_EN
        .prescale_div (prescale_div),
`endif
        .counter      (counter),
        .window_idx   (window_idx),
        .cycle_idx    (cycle_idx),
        .window_start (window_start),
        .intflag      (intflag),
        .ch_armed     (ch_armed),
        .tpu_int      (tpu_int)
    );

    always #5 sys_clock = ~sys_clock;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_on   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int unsigned       m_cnt;
    int unsigned       m_presc;
    logic              m_ws;
    logic              m_int;
    logic [NUM_CH-1:0] m_flag, m_armed, m_mask, m_oneshot;
    int unsigned       m_cmp [NUM_CH];

    always @(posedge sys_clock) begin : model
        logic [NUM_CH-1:0] hit;
        logic [NUM_CH-1:0] nf, na, nm, no;
        logic              step;
        int unsigned       nc;
        if (reset) begin
            m_cnt     <= 0;
            m_presc   <= 0;
            m_ws      <= 1'b0;
            m_int     <= 1'b0;
            m_flag    <= '0;
            m_armed   <= '0;
            m_mask    <= '0;
            m_oneshot <= '0;
            for (int i = 0; i < NUM_CH; i++) m_cmp[i] <= 0;
        end else begin
            nf = m_flag; na = m_armed; nm = m_mask; no = m_oneshot;
            for (int i = 0; i < NUM_CH; i++) begin
                hit[i] = m_armed[i] && (m_cmp[i] == m_cnt);
                if (bus.cfg_wr && (int'(bus.cfg_idx) == i)) begin
                    m_cmp[i] <= int'(bus.cfg_cmp);
                    na[i] = bus.cfg_en;
                    no[i] = bus.cfg_oneshot;
                    nm[i] = bus.cfg_mask;
                    nf[i] = 1'b0;
                end else if (hit[i]) begin
                    nf[i] = 1'b1;
                    if (m_oneshot[i]) na[i] = 1'b0;
                end else if (bus.flag_clr[i]) begin
                    nf[i] = 1'b0;
                end
            end
            m_int <= |(m_flag & m_mask);
            m_flag <= nf; m_armed <= na; m_mask <= nm; m_oneshot <= no;
`ifdef TPU_PRESCALER_EN
            step = cnt_en && (m_presc >= int'(prescale_div));
            if (rsttpu) m_presc <= 0;
            else if (cnt_en) m_presc <= (m_presc >= int'(prescale_div)) ? 0 : m_presc + 1;
`else
            step = cnt_en;
`endif
            if (rsttpu) begin
                m_cnt <= 0;
                m_ws  <= 1'b1;
            end else if (step) begin
                nc = (m_cnt + 1) % MOD;
                m_cnt <= nc;
                m_ws  <= ((nc % CYCMOD) == 0);
            end else begin
                m_ws <= 1'b0;
            end
        end
    end

    always @(negedge sys_clock) begin
        if (cmp_on) begin
            check("counter", 64'(counter), 64'(m_cnt));
            check("window_idx", 64'(window_idx), 64'(m_cnt / CYCMOD));
            check("cycle_idx", 64'(cycle_idx), 64'(m_cnt % CYCMOD));
            check("window_start", 64'(window_start), 64'(m_ws));
            check("intflag", 64'(intflag), 64'(m_flag));
            check("ch_armed", 64'(ch_armed), 64'(m_armed));
            check("tpu_int", 64'(tpu_int), 64'(m_int));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge sys_clock);
        #1;
        reset        = 1'b0;
        rsttpu       = 1'b0;
        bus.cfg_wr   = 1'b0;
        bus.flag_clr = '0;
    endtask

    task automatic cfg_write(input int unsigned idx, input int unsigned cmp, input bit en,
                             input bit oneshot, input bit mask);
        bus.cfg_wr      = 1'b1;
        bus.cfg_idx     = IDX_W'(idx);
        bus.cfg_cmp     = CNT_W'(cmp);
        bus.cfg_en      = en;
        bus.cfg_oneshot = oneshot;
        bus.cfg_mask    = mask;
    endtask

    task automatic run_until(input int unsigned val, input int budget);
        int n = 0;
        while ((int'(counter) != val) && (n < budget)) begin
            tick();
            n++;
        end
        check("run_until_reached", 64'(counter), 64'(val));
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    logic [NUM_CH-1:0] snap_flag, snap_armed;
    int                ws_pulses;

    initial begin : stim
        reset = 1'b1; rsttpu = 1'b0; cnt_en = 1'b0;
        bus.cfg_wr = 1'b0; bus.cfg_idx = '0; bus.cfg_cmp = '0;
        bus.cfg_en = 1'b0; bus.cfg_oneshot = 1'b0; bus.cfg_mask = 1'b0; bus.flag_clr = '0;
`ifdef TPU_PRESCALER_EN
        prescale_div = 8'd0;
`endif
        tick();
        cmp_on = 1'b1;
        check("rst_counter", 64'(counter), 64'd0);
        check("rst_intflag", 64'(intflag), 64'd0);
        check("rst_armed", 64'(ch_armed), 64'd0);
        check("rst_int", 64'(tpu_int), 64'd0);
        check("rst_ws", 64'(window_start), 64'd0);
        tick();
        check("idle_no_ws", 64'(window_start), 64'd0);

        // Test 1: 600 counting cycles
        cnt_en = 1'b1;
        ws_pulses = 0;
        for (int k = 0; k < 600; k++) begin
            tick();
            if (window_start) begin
                ws_pulses++;
                check("t1_ws_at_512", 64'(counter), 64'd512);
            end
        end
        check("t1_counter", 64'(counter), 64'd600);
        check("t1_window_idx", 64'(window_idx), 64'd1);
        check("t1_cycle_idx", 64'(cycle_idx), 64'd88);
        check("t1_ws_pulses", 64'(ws_pulses), 64'd1);

        // Tests 2/3: periodic ch0 at 0x10, one-shot ch1 at 5
        cnt_en = 1'b0;
        rsttpu = 1'b1;
        cfg_write(0, 'h10, 1'b1, 1'b0, 1'b1);
        tick();
        check("t2_rsttpu_counter", 64'(counter), 64'd0);
        check("t2_rsttpu_ws", 64'(window_start), 64'd1);
        cfg_write(1, 5, 1'b1, 1'b1, 1'b0);
        tick();
        cnt_en = 1'b1;
        run_until(5, 10);
        tick();
        check("t3_flag1", 64'(intflag[1]), 64'd1);
        check("t3_disarmed1", 64'(ch_armed[1]), 64'd0);
        run_until('h10, 20);
        check("t2_flag0_before", 64'(intflag[0]), 64'd0);
        tick();
        check("t2_flag0", 64'(intflag[0]), 64'd1);
        check("t2_armed0", 64'(ch_armed[0]), 64'd1);
        check("t2_int_lag", 64'(tpu_int), 64'd0);
        tick();
        check("t2_int", 64'(tpu_int), 64'd1);
        bus.flag_clr = 4'b0011;
        tick();
        check("t2_clr_flags", 64'(intflag[1:0]), 64'd0);
        tick();
        check("t2_int_drop", 64'(tpu_int), 64'd0);
        run_until('hFFFF, 70000);
        cfg_write(0, 'h10, 1'b1, 1'b0, 1'b1);
        tick();
        check("t2_wrap_counter", 64'(counter), 64'd0);
        check("t2_wrap_ws", 64'(window_start), 64'd1);
        run_until('h10, 20);
        tick();
        check("t2_rematch", 64'(intflag[0]), 64'd1);
        check("t3_no_reset", 64'(intflag[1]), 64'd0);
        check("t3_still_disarmed", 64'(ch_armed[1]), 64'd0);

        // Test 4: clear loses to match; masked-off flag keeps tpu_int low
        bus.flag_clr = 4'b0001;
        cfg_write(2, 'h30, 1'b1, 1'b0, 1'b0);
        tick();
        run_until('h30, 40);
        bus.flag_clr = 4'b0100;
        tick();
        check("t4_match_wins", 64'(intflag[2]), 64'd1);
        tick();
        tick();
        check("t4_masked_int", 64'(tpu_int), 64'd0);
        check("t4_flag_kept", 64'(intflag[2]), 64'd1);

        // Test 5: rsttpu mid-count, cmp==0 channel matches right after
        cfg_write(3, 0, 1'b1, 1'b0, 1'b0);
        tick();
        run_until('h123, 300);
        snap_flag  = intflag;
        snap_armed = ch_armed;
        rsttpu = 1'b1;
        tick();
        check("t5_counter", 64'(counter), 64'd0);
        check("t5_ws", 64'(window_start), 64'd1);
        check("t5_flags_kept", 64'(intflag), 64'(snap_flag));
        check("t5_armed_kept", 64'(ch_armed), 64'(snap_armed));
        tick();
        check("t5_cmp0_match", 64'(intflag[3]), 64'd1);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            reset  = ($urandom_range(0, 999) < 3);
            rsttpu = ($urandom_range(0, 99) == 0);
            cnt_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) begin
                cfg_write($urandom_range(0, NUM_CH - 1),
                          (int'(counter) + $urandom_range(0, 40)) % MOD,
                          ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 9) == 0) bus.flag_clr = NUM_CH'($urandom_range(0, 15));
`ifdef TPU_PRESCALER_EN
            prescale_div = 8'($urandom_range(0, 2));
`endif
            tick();
        end

        // Reset mid-count
        cnt_en = 1'b1;
`ifdef TPU_PRESCALER_EN
        prescale_div = 8'd0;
`endif
        cfg_write(0, 'h5, 1'b1, 1'b0, 1'b1);
        tick();
        repeat (20) tick();
        reset = 1'b1;
        tick();
        check("t5_reset_counter", 64'(counter), 64'd0);
        check("t5_reset_flags", 64'(intflag), 64'd0);
        check("t5_reset_armed", 64'(ch_armed), 64'd0);
        check("t5_reset_int", 64'(tpu_int), 64'd0);
        check("t5_reset_ws", 64'(window_start), 64'd0);

`ifdef TPU_PRESCALER_EN
        // Test 6: divide by 4
        cnt_en = 1'b0;
        prescale_div = 8'd3;
        cfg_write(3, 2, 1'b1, 1'b0, 1'b1);
        tick();
        cnt_en = 1'b1;
        begin
            int   sets = 0;
            logic prev = intflag[3];
            for (int k = 0; k < 40; k++) begin
                tick();
                if (intflag[3] && !prev) sets++;
                prev = intflag[3];
            end
            check("t6_counter", 64'(counter), 64'd10);
            check("t6_single_set", 64'(sets), 64'd1);
        end
`endif

        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
